// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point MAC datapath: default Q-format,
// accumulator width derivation and scalar scale/saturate helpers.
package fxp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;
  localparam int DEF_LEN   = 4;
  localparam int DEF_GUARD = 4;

  // Q-format constants for the default configuration (Q8.8).
  localparam logic signed [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1 << DEF_FRAC);
  localparam logic signed [DEF_WIDTH-1:0] MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  // Full-precision product is 2*width; guard bits absorb the LEN-term growth.
  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Scalar reference of the output scaling: arithmetic shift right by frac,
  // optionally biased by half an LSB first (round-half-up).
  function automatic longint scale(input longint v, input int frac, input bit round);
    longint b;
    b = v;
    if (round && frac > 0) b = b + (longint'(1) <<< (frac - 1));
    return b >>> frac;
  endfunction

  // Scalar reference of the clamp to a width-bit two's complement range.
  function automatic longint sat(input longint v, input int width);
    longint hi, lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fxp_sat_round.sv
// Combinational rescale of an ACC_W-bit accumulator to a WIDTH-bit result:
// shift right by FRAC (floor, or round-half-up when FXP_ROUND_EN is defined),
// then clamp to the signed WIDTH-bit range and flag when clamping happened.
module fxp_sat_round
  import fxp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = acc_w(DEF_WIDTH, DEF_GUARD)
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] res,
  output logic                    ovf
);

  // One extra MSB so the rounding bias can never wrap.
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] scaled;

`ifdef FXP_ROUND_EN
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << FRAC >> 1;
  assign biased = {acc[ACC_W-1], acc} + HALF;
`else
  assign biased = {acc[ACC_W-1], acc};
`endif

  assign scaled = biased >>> FRAC;

  // Clamp after scaling so rounding can itself push a value into saturation.
  always_comb begin
    res = scaled[WIDTH-1:0];
    ovf = 1'b0;
    if (scaled > MAXV) begin
      res = MAXV[WIDTH-1:0];
      ovf = 1'b1;
    end else if (scaled < MINV) begin
      res = MINV[WIDTH-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_mac.sv
// Signed fixed-point multiply-accumulate: sums LEN products at full precision
// and emits one rescaled, saturated result per LEN accepted (in, w) pairs.
// Stage 1 registers the product, stage 2 accumulates and loads the result.
// Build option FXP_ROUND_EN selects round-half-up instead of floor scaling.
module fxp_mac
  import fxp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int LEN   = DEF_LEN,
  parameter int GUARD = DEF_GUARD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in,
  input  logic signed [WIDTH-1:0] w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out,
  output logic                    ovf
);

  localparam int ACC_W = acc_w(WIDTH, GUARD);
  localparam int CW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0]            cnt;
  logic signed [2*WIDTH-1:0] p;
  logic                     p_valid, p_first, p_last;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic signed [WIDTH-1:0]  res;
  logic                     res_ovf;
  logic                     stall, take;

  // The only hazard: a finished sum cannot land while the held result is unread.
  assign stall    = p_valid && p_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign take     = in_valid && in_ready;

  assign acc_next = p_first ? ACC_W'(p) : acc + ACC_W'(p);

  fxp_sat_round #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_sat (
    .acc (acc_next),
    .res (res),
    .ovf (res_ovf)
  );

  // Stage 1: register the product and tag its position within the vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      p       <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (!stall) begin
      p_valid <= take;
      if (take) begin
        p       <= in * w;
        p_first <= (cnt == '0);
        p_last  <= (cnt == LAST);
        cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Stage 2: accumulate; on the last term load the result, which takes
  // priority over clearing out_valid when the old one is accepted together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      out       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (p_valid && !stall) acc <= acc_next;
      if (p_valid && p_last && !stall) begin
        out       <= res;
        ovf       <= res_ovf;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mac.sv
// Self-checking bench for fxp_mac (Q8.8, LEN=4): directed vector table,
// hand-written backpressure/reset sequences and a randomized phase checked
// by an arithmetic reference model of the dot product.
module tb_fxp_mac;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int LEN   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_d, w_d;
  logic        out_valid, out_ready;
  logic [15:0] out_d;
  logic        ovf;

  int n_pass = 0;
  int n_total = 0;
  int n_deliv = 0;
  int cyc = 0;

  fxp_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .LEN(LEN), .GUARD(4)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_d),
    .w         (w_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_d),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] r; logic o; } res_t;
  res_t   exp_q[$];
  longint m_sum = 0;
  int     m_cnt = 0;

  function automatic res_t model_res(input longint s);
    res_t   x;
    longint v;
    longint hi, lo;
    v = s;
`ifdef FXP_ROUND_EN
    v = v + (longint'(1) <<< (FRAC - 1));
`endif
    v = v >>> FRAC;
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (WIDTH - 1));
    x.o = 1'b1;
    if (v > hi)      x.r = 16'h7FFF;
    else if (v < lo) x.r = 16'h8000;
    else begin
      x.r = v[15:0];
      x.o = 1'b0;
    end
    return x;
  endfunction

  // Monitor at negedge: outputs and inputs are stable between edges.
  initial begin : monitor
    bit          held;
    logic [15:0] h_out;
    logic        h_ovf;
    res_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_sum = 0;
        m_cnt = 0;
        exp_q.delete();
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_out", out_d, h_out);
          chk("hold_ovf", ovf, h_ovf);
        end
        if (out_valid && out_ready) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_out", out_d, e.r);
            chk("sb_ovf", ovf, e.o);
          end
        end
        held  = out_valid && !out_ready;
        h_out = out_d;
        h_ovf = ovf;
        if (in_valid && in_ready) begin
          m_sum = m_sum + longint'($signed(in_d)) * longint'($signed(w_d));
          m_cnt++;
          if (m_cnt == LEN) begin
            exp_q.push_back(model_res(m_sum));
            m_sum = 0;
            m_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    string            name;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]      exp_out;
    logic             exp_ovf;
  } vec_t;

  vec_t tab[7];

  function automatic vec_t mk(input string n, input logic [15:0] a0, b0, ar, br,
                              input logic [15:0] eo, input logic ef);
    vec_t v;
    v.name = n;
    v.a[0] = a0; v.b[0] = b0;
    for (int j = 1; j < 4; j++) begin
      v.a[j] = ar;
      v.b[j] = br;
    end
    v.exp_out = eo;
    v.exp_ovf = ef;
    return v;
  endfunction

  // Caller must be just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_d = a;
    w_d = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) send(v.a[j], v.b[j]);
    in_valid = 1'b0;
    @(negedge clk);
    chk({v.name, "_early"}, out_valid, 0);
    @(negedge clk);
    chk({v.name, "_valid"}, out_valid, 1);
    chk({v.name, "_out"}, out_d, v.exp_out);
    chk({v.name, "_ovf"}, ovf, v.exp_ovf);
  endtask

  initial begin
    int base, t0;
    tab[0] = mk("one", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0400, 1'b0);
    tab[1] = mk("neg", 16'hFFFF, 16'h0200, 16'hFFFF, 16'h0200, 16'hFFF8, 1'b0);
    tab[2] = mk("big", 16'h1100, 16'h0100, 16'h1100, 16'h0100, 16'h4400, 1'b0);
    tab[3] = mk("satp", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    tab[4] = mk("satn", 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);
`ifdef FXP_ROUND_EN
    tab[5] = mk("rnd_pos", 16'h0001, 16'h0080, 16'h0000, 16'h0000, 16'h0001, 1'b0);
    tab[6] = mk("rnd_neg", 16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0);
`else
    tab[5] = mk("rnd_pos", 16'h0001, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tab[6] = mk("rnd_neg", 16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_d = '0; w_d = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out_d, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Table: each vector with exact 2-cycle latency.
    for (int i = 0; i < 7; i++) run_vec(tab[i]);

    // Back-to-back vectors: 8 pairs in 8 cycles, both results delivered.
    @(posedge clk); #1;
    base = n_deliv;
    t0 = cyc;
    for (int j = 0; j < 4; j++) send(16'hFFFF, 16'h0200);
    for (int j = 0; j < 4; j++) send(16'h1100, 16'h0100);
    in_valid = 1'b0;
    chk("b2b_cycles", cyc - t0, 8);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_deliv", n_deliv - base, 2);

    // Backpressure: two vectors while the output is blocked.
    out_ready = 1'b0;
    base = n_deliv;
    for (int j = 0; j < 4; j++) send(16'h0100, 16'h0100);
    for (int j = 0; j < 4; j++) send(16'hFFFF, 16'h0200);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_out", out_d, 16'h0400);
    repeat (3) @(negedge clk);
    chk("bp_in_ready_hold", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", out_d, 16'h0400);
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second", out_d, 16'hFFF8);
    @(posedge clk); #1;
    chk("bp_deliv", n_deliv - base, 2);
    chk("bp_drained", out_valid, 0);

    // Reset after 2 of 4 pairs; the partial sum must not leak.
    @(posedge clk); #1;
    send(16'h0300, 16'h0100);
    send(16'h0300, 16'h0100);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    run_vec(tab[0]);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        in_d = 16'($urandom);
        w_d  = 16'($urandom);
      end else begin
        in_d = 16'($urandom_range(0, 2047)) - 16'd1024;
        w_d  = 16'($urandom_range(0, 2047)) - 16'd1024;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
